// File: rtl/spi_shifter_if.sv
// SPI shifter port bundle: control, strobes, serial and RX status.
// SPI_RX_OVERRUN_EN adds rx_overrun to the bundle.
interface spi_shifter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  ss;
  logic                  cpol;
  logic                  cpha;
  logic                  lsbfe;
  logic                  send_data;
  logic [DATA_WIDTH-1:0] data_mosi;
  logic                  mosi_send_sclk;
  logic                  mosi_send_sclk0;
  logic                  miso_recieve_sclk;
  logic                  miso_recieve_sclk0;
  logic                  miso;
  logic                  rx_read;
  logic                  mosi;
  logic [DATA_WIDTH-1:0] data_miso;
  logic                  rx_valid;
  logic                  busy;
  logic                  frame_done;
`ifdef SPI_RX_OVERRUN_EN
  logic                  rx_overrun;
`endif

  modport master (
    output ss, cpol, cpha, lsbfe,
    output send_data, data_mosi,
    output mosi_send_sclk, mosi_send_sclk0,
    output miso_recieve_sclk,
    output miso_recieve_sclk0,
    output miso, rx_read,
`ifdef SPI_RX_OVERRUN_EN
    input  rx_overrun,
`endif
    input  mosi, data_miso, rx_valid,
    input  busy, frame_done
  );

  modport slave (
    input  ss, cpol, cpha, lsbfe,
    input  send_data, data_mosi,
    input  mosi_send_sclk, mosi_send_sclk0,
    input  miso_recieve_sclk,
    input  miso_recieve_sclk0,
    input  miso, rx_read,
`ifdef SPI_RX_OVERRUN_EN
    output rx_overrun,
`endif
    output mosi, data_miso, rx_valid,
    output busy, frame_done
  );
endinterface

// File: rtl/spi_shifter.sv
// SPI master serial data path: TX shift-out, RX assemble, frame status.
// Optional SPI_RX_OVERRUN_EN: rx_overrun flag on unread-byte overwrite.
module spi_shifter #(
  parameter int DATA_WIDTH = 8
) (
  input logic         Pclk,
  input logic         PRESET_n,
  spi_shifter_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int IW = $clog2(DW);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] DWC = CW'(DW);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  state_t        state;
  logic [DW-1:0] tx_sr;
  logic [DW-1:0] rx_sr;
  logic          dir;
  logic [CW-1:0] tx_cnt;
  logic [CW-1:0] rx_cnt;
  logic          mosi;
  logic [DW-1:0] data_miso;
  logic          rx_valid;
  logic          busy;
  logic          frame_done;
`ifdef SPI_RX_OVERRUN_EN
  logic          rx_overrun;
`endif

  logic          mode03;
  logic          tx_stb;
  logic          rx_stb;
  logic [IW-1:0] nidx;
  logic          first;
  logic [DW-1:0] rx_nxt;

  assign mode03 = (bus.cpol == bus.cpha);
  assign tx_stb = mode03 ? bus.mosi_send_sclk
                         : bus.mosi_send_sclk0;
  assign rx_stb = mode03 ? bus.miso_recieve_sclk
                         : bus.miso_recieve_sclk0;

  // tx_sr stays static; the bit counter selects the bit
  assign nidx  = dir ? tx_cnt[IW-1:0]
                     : IW'(DW - 1) - tx_cnt[IW-1:0];
  assign first = dir ? tx_sr[0] : tx_sr[DW-1];
  assign rx_nxt = dir ? {bus.miso, rx_sr[DW-1:1]}
                      : {rx_sr[DW-2:0], bus.miso};

  always_ff @(posedge Pclk or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state      <= IDLE;
      tx_sr      <= '0;
      rx_sr      <= '0;
      dir        <= 1'b0;
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      mosi       <= 1'b0;
      data_miso  <= '0;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef SPI_RX_OVERRUN_EN
      rx_overrun <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (bus.rx_read) begin
        rx_valid <= 1'b0;
`ifdef SPI_RX_OVERRUN_EN
        rx_overrun <= 1'b0;
`endif
      end
      unique case (state)
        IDLE: begin
          mosi <= 1'b0;
          if (bus.send_data && !bus.ss) begin
            state  <= LOAD;
            tx_sr  <= bus.data_mosi;
            dir    <= bus.lsbfe;
            tx_cnt <= '0;
            rx_cnt <= '0;
            busy   <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.ss) begin
            state <= IDLE;
            busy  <= 1'b0;
            mosi  <= 1'b0;
          end else begin
            mosi   <= first;
            tx_cnt <= CW'(1);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.ss) begin
            state <= IDLE;
            busy  <= 1'b0;
            mosi  <= 1'b0;
          end else begin
            if (tx_stb && tx_cnt < DWC) begin
              mosi   <= tx_sr[nidx];
              tx_cnt <= tx_cnt + CW'(1);
            end
            if (rx_stb) begin
              rx_sr  <= rx_nxt;
              rx_cnt <= rx_cnt + CW'(1);
              if (rx_cnt == DWC - CW'(1)) begin
                data_miso  <= rx_nxt;
                rx_valid   <= 1'b1;
                frame_done <= 1'b1;
                busy       <= 1'b0;
                state      <= IDLE;
`ifdef SPI_RX_OVERRUN_EN
                if (rx_valid && !bus.rx_read)
                  rx_overrun <= 1'b1;
`endif
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mosi       = mosi;
  assign bus.data_miso  = data_miso;
  assign bus.rx_valid   = rx_valid;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;
`ifdef SPI_RX_OVERRUN_EN
  assign bus.rx_overrun = rx_overrun;
`endif
endmodule

// File: tb/tb_spi_shifter.sv
// Directed and random frames for spi_shifter against a bit-order model.
// Overrun checks compile in with SPI_RX_OVERRUN_EN.
module tb_spi_shifter;
  logic Pclk;
  logic PRESET_n;
  int   total;
  int   bad;

  spi_shifter_if #(.DATA_WIDTH(8)) bus();

  spi_shifter #(.DATA_WIDTH(8)) dut (
    .Pclk     (Pclk),
    .PRESET_n (PRESET_n),
    .bus      (bus)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  logic       gcp;
  logic       gch;
  bit         gnoise;
  logic [7:0] got;
  logic       mv;
  logic       mo;
  logic [7:0] mdata;

  task automatic step();
    @(posedge Pclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_stb(input bit tx, input bit rx);
    if (gcp == gch) begin
      bus.mosi_send_sclk     = tx;
      bus.miso_recieve_sclk  = rx;
      bus.mosi_send_sclk0    = gnoise;
      bus.miso_recieve_sclk0 = gnoise;
    end else begin
      bus.mosi_send_sclk0    = tx;
      bus.miso_recieve_sclk0 = rx;
      bus.mosi_send_sclk     = gnoise;
      bus.miso_recieve_sclk  = gnoise;
    end
  endtask

  task automatic start(input logic cp, input logic ch,
                       input logic lsb, input logic [7:0] d,
                       input bit noise);
    gcp = cp;
    gch = ch;
    gnoise = noise;
    bus.cpol = cp;
    bus.cpha = ch;
    bus.lsbfe = lsb;
    bus.data_mosi = d;
    bus.send_data = 1'b1;
    drive_stb(0, 0);
    step();
    bus.send_data = 1'b0;
    bus.lsbfe = ~lsb;
    bus.data_mosi = ~d;
    chk("busy_load", bus.busy, 1);
    step();
    chk("mosi_first", bus.mosi, lsb ? d[0] : d[7]);
  endtask

  task automatic bits(input int from, input int to,
                      input logic lsb, input logic [7:0] d,
                      input bit loop, input logic [7:0] pat,
                      input bit rd);
    for (int i = from; i < to; i++) begin
      logic b;
      chk("mosi_bit", bus.mosi, lsb ? d[i] : d[7-i]);
      b = loop ? bus.mosi : (lsb ? pat[i] : pat[7-i]);
      bus.miso = b;
      if (lsb) got[i] = b;
      else got[7-i] = b;
      drive_stb(0, 1);
      bus.rx_read = (i == 7) ? rd : 1'b0;
      step();
      drive_stb(0, 0);
      bus.rx_read = 1'b0;
      if (i < 7) begin
        chk("no_done", bus.frame_done, 0);
        drive_stb(1, 0);
        step();
        drive_stb(0, 0);
        step();
      end
    end
  endtask

  task automatic end_frame(input bit rd);
    mo = (mv && !rd) ? 1'b1 : (rd ? 1'b0 : mo);
    mv = 1'b1;
    mdata = got;
    chk("done_pulse", bus.frame_done, 1);
    chk("data_miso", bus.data_miso, mdata);
    chk("rx_valid", bus.rx_valid, mv);
`ifdef SPI_RX_OVERRUN_EN
    chk("overrun", bus.rx_overrun, mo);
`endif
    step();
    chk("done_low", bus.frame_done, 0);
    chk("busy_idle", bus.busy, 0);
    chk("mosi_idle", bus.mosi, 0);
    gnoise = 0;
    drive_stb(0, 0);
  endtask

  task automatic frame(input logic cp, input logic ch,
                       input logic lsb, input logic [7:0] d,
                       input bit loop, input logic [7:0] pat,
                       input bit noise, input bit rd);
    start(cp, ch, lsb, d, noise);
    bits(0, 8, lsb, d, loop, pat, rd);
    end_frame(rd);
  endtask

  task automatic read_rx();
    bus.rx_read = 1'b1;
    step();
    bus.rx_read = 1'b0;
    mv = 1'b0;
    mo = 1'b0;
    chk("rx_valid_clr", bus.rx_valid, 0);
`ifdef SPI_RX_OVERRUN_EN
    chk("overrun_clr", bus.rx_overrun, 0);
`endif
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] p;
    total = 0;
    bad = 0;
    mv = 0;
    mo = 0;
    mdata = 0;
    got = 0;
    gcp = 0;
    gch = 0;
    gnoise = 0;
    PRESET_n = 1'b0;
    bus.ss = 1'b0;
    bus.cpol = 1'b0;
    bus.cpha = 1'b0;
    bus.lsbfe = 1'b0;
    bus.send_data = 1'b0;
    bus.data_mosi = '0;
    bus.miso = 1'b0;
    bus.rx_read = 1'b0;
    drive_stb(0, 0);
    #12;
    chk("rst_mosi", bus.mosi, 0);
    chk("rst_data", bus.data_miso, 0);
    chk("rst_valid", bus.rx_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.frame_done, 0);
`ifdef SPI_RX_OVERRUN_EN
    chk("rst_ovr", bus.rx_overrun, 0);
`endif
    step();
    PRESET_n = 1'b1;
    step();

    frame(0, 0, 0, 8'hA5, 1, 8'h00, 0, 0);
    chk("t1_data", bus.data_miso, 8'hA5);
    read_rx();

    frame(1, 1, 1, 8'h01, 0, 8'hFF, 0, 0);
    chk("t2_data", bus.data_miso, 8'hFF);

    frame(0, 1, 0, 8'h96, 0, 8'h3C, 1, 1);
    chk("t3_data", bus.data_miso, 8'h3C);

    start(1, 1, 0, 8'hC3, 0);
    bits(0, 4, 0, 8'hC3, 0, 8'h55, 0);
    bus.ss = 1'b1;
    step();
    chk("abort_busy", bus.busy, 0);
    chk("abort_mosi", bus.mosi, 0);
    chk("abort_data", bus.data_miso, 8'h3C);
    chk("abort_valid", bus.rx_valid, mv);
    chk("abort_done", bus.frame_done, 0);
    bus.send_data = 1'b1;
    step();
    bus.send_data = 1'b0;
    chk("ss_ignored", bus.busy, 0);
    bus.ss = 1'b0;
    read_rx();

    d = 8'($urandom);
    p = 8'($urandom);
    frame(1, 0, 0, d, 0, p, 0, 0);
    d = 8'($urandom);
    p = 8'($urandom);
    frame(1, 0, 1, d, 0, p, 0, 0);
    chk("t5_data", bus.data_miso, p);
    chk("t5_valid", bus.rx_valid, 1);
    read_rx();

    start(0, 0, 1, 8'h5A, 0);
    bits(0, 3, 1, 8'h5A, 1, 8'h00, 0);
    PRESET_n = 1'b0;
    #2;
    mv = 0;
    mo = 0;
    mdata = 0;
    chk("arst_mosi", bus.mosi, 0);
    chk("arst_data", bus.data_miso, 0);
    chk("arst_valid", bus.rx_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.frame_done, 0);
    step();
    PRESET_n = 1'b1;
    step();

    start(0, 0, 0, 8'h6E, 0);
    bits(0, 3, 0, 8'h6E, 1, 8'h00, 0);
    bus.data_mosi = 8'h11;
    bus.lsbfe = 1'b1;
    bus.send_data = 1'b1;
    step();
    bus.send_data = 1'b0;
    chk("busy_send", bus.busy, 1);
    bits(3, 8, 0, 8'h6E, 1, 8'h00, 0);
    end_frame(0);
    chk("no_restart", bus.data_miso, 8'h6E);

    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      p = 8'($urandom);
      frame(1'($urandom), 1'($urandom), 1'($urandom),
            d, 1'($urandom), p, 1'($urandom),
            1'($urandom));
      if ($urandom_range(0, 2) == 0) read_rx();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
